cpu_phase_sequencer: RTL and testbench

- Parametrised successor to the fixed 8-strobe cpu_clock generator.
- Emits one-hot phase strobes that sequence fetch, decode, select, ALU and writeback for the multi-cycle CPU.
- Supports a configurable phase count and per-instruction variable length taken from decode's length field.
- Adds stall, run/stop, single-step mode and a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/cpu_phase_sequencer_phase_decoder.sv | 20 ++
 rtl/cpu_phase_sequencer.sv | 114 +++++++++++
 tb/tb_cpu_phase_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, default phase count and
// named phase indices used by the datapath blocks.
package cpu_pkg;

    localparam int DEF_NUM_PHASES = 8;

    localparam int PH_FETCH  = 0;
    localparam int PH_DECODE = 1;
    localparam int PH_SELECT = 2;
    localparam int PH_EXEC   = 3;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_HALT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/cpu_phase_sequencer_phase_decoder.sv
// Binary phase index to one-hot strobe; all strobes low when disabled.
module phase_decoder #(
    parameter int NUM_PHASES = 8,
    parameter int PHASE_W    = 4
) (
    input  logic                  i_en,
    input  logic [PHASE_W-1:0]    i_idx,
    output logic [NUM_PHASES-1:0] o_phase
);

    always_comb begin
        o_phase = '0;
        if (i_en) begin
            for (int k = 0; k < NUM_PHASES; k++) begin
                if (i_idx == PHASE_W'(k)) o_phase[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle CPU phase sequencer with variable instruction length, stall,
// run/stop, single-step and a retired-instruction counter.
module cpu_phase_sequencer
    import cpu_pkg::*;
#(
    parameter int NUM_PHASES      = DEF_NUM_PHASES,
    parameter int PHASE_W         = 4,
    parameter int LEN_LATCH_PHASE = PH_DECODE,
    parameter int CNT_W           = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_run,
    input  logic                  i_stall,
    input  logic                  i_step_mode,
    input  logic                  i_step,
    input  logic [PHASE_W-1:0]    i_instr_len,
    output logic [NUM_PHASES-1:0] o_phase,
    output logic [PHASE_W-1:0]    o_phase_idx,
    output logic                  o_instr_done,
    output logic                  o_busy,
    output logic [CNT_W-1:0]      o_instr_count
);

    // One extra bit so a length equal to 2**PHASE_W is representable.
    localparam int LEN_W = PHASE_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(NUM_PHASES);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(LEN_LATCH_PHASE + 2);

    seq_state_e         r_state, w_state_nxt;
    logic [PHASE_W-1:0] r_phase_idx, w_idx_nxt;
    logic [LEN_W-1:0]   r_len, w_len_nxt;
    logic [CNT_W-1:0]   r_count, w_cnt_nxt;
    logic               w_in_run;
    logic               w_last;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [PHASE_W-1:0] len);
        logic [LEN_W-1:0] l;
        l = {1'b0, len};
        if (l == '0 || l > LEN_MAX) return LEN_MAX;
        else if (l < LEN_MIN)       return LEN_MIN;
        else                        return l;
    endfunction

    assign w_in_run = (r_state == SEQ_RUN);
    assign w_last   = w_in_run && ({1'b0, r_phase_idx} == r_len - LEN_W'(1));

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= SEQ_IDLE;
            r_phase_idx <= '0;
            r_len       <= LEN_MAX;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase_idx <= w_idx_nxt;
            r_len       <= w_len_nxt;
            r_count     <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_phase_idx;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_count;
        case (r_state)
            SEQ_IDLE: begin
                w_idx_nxt = '0;
                if (i_run) w_state_nxt = SEQ_RUN;
            end
            SEQ_RUN: begin
                if (!i_stall) begin
                    if (w_last) begin
                        w_cnt_nxt = r_count + CNT_W'(1);
                        w_len_nxt = LEN_MAX;
                        w_idx_nxt = '0;
                        if (!i_run)          w_state_nxt = SEQ_IDLE;
                        else if (i_step_mode) w_state_nxt = SEQ_HALT;
                    end else begin
                        w_idx_nxt = r_phase_idx + PHASE_W'(1);
                        // Decode drives the length during its own phase.
                        if (r_phase_idx == PHASE_W'(LEN_LATCH_PHASE))
                            w_len_nxt = clamp_len(i_instr_len);
                    end
                end
            end
            SEQ_HALT: begin
                w_idx_nxt = '0;
                if (!i_run)                       w_state_nxt = SEQ_IDLE;
                else if (i_step || !i_step_mode)  w_state_nxt = SEQ_RUN;
            end
            default: begin
                w_state_nxt = SEQ_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    phase_decoder #(
        .NUM_PHASES (NUM_PHASES),
        .PHASE_W    (PHASE_W)
    ) u_phase_decoder (
        .i_en    (w_in_run),
        .i_idx   (r_phase_idx),
        .o_phase (o_phase)
    );

    assign o_phase_idx   = r_phase_idx;
    assign o_instr_done  = w_last;
    assign o_busy        = w_in_run;
    assign o_instr_count = r_count;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed self-checking bench for cpu_phase_sequencer (8 phases, 8-bit counter).
module tb_cpu_phase_sequencer;

    localparam int NP = 8;
    localparam int PW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset, run, stall, step_mode, step;
    logic [PW-1:0] instr_len;
    logic [NP-1:0] phase;
    logic [PW-1:0] phase_idx;
    logic          instr_done, busy;
    logic [CW-1:0] instr_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_phase_sequencer #(
        .NUM_PHASES      (NP),
        .PHASE_W         (PW),
        .LEN_LATCH_PHASE (1),
        .CNT_W           (CW)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_run         (run),
        .i_stall       (stall),
        .i_step_mode   (step_mode),
        .i_step        (step),
        .i_instr_len   (instr_len),
        .o_phase       (phase),
        .o_phase_idx   (phase_idx),
        .o_instr_done  (instr_done),
        .o_busy        (busy),
        .o_instr_count (instr_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walks phases 0..len-1 of one instruction, checking strobe and done.
    task automatic walk(input string name, input int len);
        logic [NP-1:0] exp;
        for (int k = 0; k < len; k++) begin
            exp = NP'(1) << k;
            total++;
            if (phase !== exp || instr_done !== (k == len - 1)) begin
                bad++;
                $display("FAIL %s k=%0d phase=%h done=%b exp phase=%h done=%b",
                         name, k, phase, instr_done, exp, (k == len - 1));
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b0; stall = 1'b0; step_mode = 1'b0; step = 1'b0;
        instr_len = 4'd8;
        tick(); tick();
        total++;
        if (phase !== '0 || phase_idx !== '0 || instr_done !== 1'b0 ||
            busy !== 1'b0 || instr_count !== '0) begin
            bad++;
            $display("FAIL reset phase=%h idx=%0d done=%b busy=%b cnt=%0d exp all 0",
                     phase, phase_idx, instr_done, busy, instr_count);
        end
        reset = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0 || phase !== '0) begin
            bad++;
            $display("FAIL idle_hold busy=%b phase=%h exp 0/0", busy, phase);
        end
    endtask

    task automatic test_full_len();
        run = 1'b1;
        tick();
        walk("full8", 8);
        total++;
        if (instr_count !== 8'd1 || phase !== 8'h01) begin
            bad++;
            $display("FAIL full8_end cnt=%0d phase=%h exp 1/01", instr_count, phase);
        end
    endtask

    task automatic test_var_len();
        instr_len = 4'd4;
        walk("len4", 4);
        total++;
        if (instr_count !== 8'd2 || phase !== 8'h01) begin
            bad++;
            $display("FAIL len4_end cnt=%0d phase=%h exp 2/01", instr_count, phase);
        end
        instr_len = 4'd1;
        walk("len1_clamp3", 3);
        total++;
        if (instr_count !== 8'd3) begin
            bad++;
            $display("FAIL len1_cnt cnt=%0d exp 3", instr_count);
        end
        instr_len = 4'd0;
        walk("len0_as8", 8);
        total++;
        if (instr_count !== 8'd4) begin
            bad++;
            $display("FAIL len0_cnt cnt=%0d exp 4", instr_count);
        end
        instr_len = 4'd12;
        walk("len12_as8", 8);
        total++;
        if (instr_count !== 8'd5) begin
            bad++;
            $display("FAIL len12_cnt cnt=%0d exp 5", instr_count);
        end
    endtask

    task automatic test_stall();
        instr_len = 4'd8;
        tick(); tick(); tick();
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (phase !== 8'h08 || phase_idx !== 4'd3 || instr_count !== 8'd5) begin
                bad++;
                $display("FAIL stall_hold c=%0d phase=%h idx=%0d cnt=%0d exp 08/3/5",
                         c, phase, phase_idx, instr_count);
            end
        end
        stall = 1'b0;
        tick();
        total++;
        if (phase !== 8'h10) begin
            bad++;
            $display("FAIL stall_resume phase=%h exp 10", phase);
        end
        tick(); tick(); tick();
        stall = 1'b1;
        tick(); tick();
        total++;
        if (phase !== 8'h80 || instr_done !== 1'b1 || instr_count !== 8'd5) begin
            bad++;
            $display("FAIL stall_last phase=%h done=%b cnt=%0d exp 80/1/5",
                     phase, instr_done, instr_count);
        end
        stall = 1'b0;
        tick();
        total++;
        if (instr_count !== 8'd6 || phase !== 8'h01) begin
            bad++;
            $display("FAIL stall_last_release cnt=%0d phase=%h exp 6/01", instr_count, phase);
        end
    endtask

    task automatic test_step();
        step_mode = 1'b1;
        instr_len = 4'd3;
        walk("step_first", 3);
        tick(); tick();
        total++;
        if (phase !== '0 || busy !== 1'b0 || instr_count !== 8'd7) begin
            bad++;
            $display("FAIL halt phase=%h busy=%b cnt=%0d exp 0/0/7", phase, busy, instr_count);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        walk("step_one", 3);
        tick();
        total++;
        if (busy !== 1'b0 || instr_count !== 8'd8) begin
            bad++;
            $display("FAIL step_one_cnt busy=%b cnt=%0d exp 0/8", busy, instr_count);
        end
        step_mode = 1'b0;
        tick();
        total++;
        if (busy !== 1'b1 || phase !== 8'h01) begin
            bad++;
            $display("FAIL stepmode_clear busy=%b phase=%h exp 1/01", busy, phase);
        end
    endtask

    task automatic test_run_drop();
        instr_len = 4'd8;
        tick(); tick();
        run = 1'b0;
        total++;
        if (phase !== 8'h04) begin
            bad++;
            $display("FAIL rundrop_at phase=%h exp 04", phase);
        end
        for (int k = 2; k < 8; k++) tick();
        total++;
        if (phase !== '0 || busy !== 1'b0 || instr_count !== 8'd9) begin
            bad++;
            $display("FAIL rundrop_idle phase=%h busy=%b cnt=%0d exp 0/0/9",
                     phase, busy, instr_count);
        end
    endtask

    task automatic test_reset_mid();
        run = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) tick();
        total++;
        if (phase !== 8'h20) begin
            bad++;
            $display("FAIL resetmid_at phase=%h exp 20", phase);
        end
        reset = 1'b0;
        tick();
        total++;
        if (phase !== '0 || phase_idx !== '0 || instr_done !== 1'b0 ||
            busy !== 1'b0 || instr_count !== '0) begin
            bad++;
            $display("FAIL resetmid phase=%h idx=%0d done=%b busy=%b cnt=%0d exp all 0",
                     phase, phase_idx, instr_done, busy, instr_count);
        end
        reset = 1'b1;
    endtask

    task automatic test_wrap();
        instr_len = 4'd3;
        tick();
        for (int k = 0; k < 255 * 3; k++) tick();
        total++;
        if (instr_count !== 8'hFF || phase !== 8'h01) begin
            bad++;
            $display("FAIL wrap_pre cnt=%h phase=%h exp FF/01", instr_count, phase);
        end
        tick(); tick(); tick();
        total++;
        if (instr_count !== 8'h00 || phase !== 8'h01) begin
            bad++;
            $display("FAIL wrap cnt=%h phase=%h exp 00/01", instr_count, phase);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_full_len();
        test_var_len();
        test_stall();
        test_step();
        test_run_drop();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
